// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared scoreboard entry type and hazard constants
package pipe_pkg;

    localparam int RA_W_MAX = 8;
    localparam int FWD_W    = 3;

    localparam logic [FWD_W-1:0]    FWD_RF   = '0;
    localparam logic [RA_W_MAX-1:0] REG_ZERO = '0;

    // rd is stored zero-extended to RA_W_MAX so one struct serves any RA_W
    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                regwrite;
        logic                memread;
    } sb_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-side hazard request/response bundle
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_uses_rs;
    logic            id_uses_rt;
    logic [RA_W-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            ex_branch_taken;
    logic            stall;
    logic            flush;
    logic            issue;
    logic [FWD_W-1:0] fwd_a;
    logic [FWD_W-1:0] fwd_b;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, ex_branch_taken,
        input  stall, flush, issue, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_regwrite, id_memread, ex_branch_taken,
        output stall, flush, issue, fwd_a, fwd_b
    );

endinterface

// File: rtl/pipe_fwd_match.sv
// rtl/pipe_fwd_match.sv - forward source select for one operand
module pipe_fwd_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  sb_entry_t [DEPTH:1]   sb,
    input  logic [RA_W_MAX-1:0]   src,
    input  logic                  src_used,
    output logic [FWD_W-1:0]      sel
);

    // Scan oldest to youngest so the youngest match is the one left in sel.
    // A load in EX has no data yet, so it is never a forward source.
    always_comb begin
        sel = FWD_RF;
        if (src_used && src != REG_ZERO) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (sb[k].valid && sb[k].regwrite && sb[k].rd == src &&
                    !(k == 1 && sb[k].memread)) begin
                    sel = FWD_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, branch flush and forwarding control
// Optional PIPE_HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PIPE_HAZARD_STATS_EN
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    pipe_hazard_ctrl_if.slave  hz
);

    generate
        if (DEPTH < 2 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_hazard_ctrl: DEPTH must be 2..4");
        end
        if (RA_W > RA_W_MAX || RA_W < 1) begin : g_bad_ra_w
            $error("pipe_hazard_ctrl: RA_W out of range");
        end
    endgenerate

    sb_entry_t [DEPTH:1]  sb;
    sb_entry_t            issue_entry;
    logic [RA_W_MAX-1:0]  rs_x;
    logic [RA_W_MAX-1:0]  rt_x;
    logic [RA_W_MAX-1:0]  rd_x;
    logic                 load_use;

    assign rs_x = RA_W_MAX'(hz.id_rs);
    assign rt_x = RA_W_MAX'(hz.id_rt);
    assign rd_x = RA_W_MAX'(hz.id_rd);

    always_comb begin
        load_use = hz.id_valid && sb[1].valid && sb[1].memread &&
                   sb[1].regwrite && sb[1].rd != REG_ZERO &&
                   ((hz.id_uses_rs && sb[1].rd == rs_x) ||
                    (hz.id_uses_rt && sb[1].rd == rt_x));
    end

    // A taken branch discards decode anyway, so it overrides the stall
    assign hz.flush = hz.ex_branch_taken;
    assign hz.stall = load_use && !hz.ex_branch_taken;
    assign hz.issue = hz.id_valid && !hz.stall && !hz.flush;

    always_comb begin
        issue_entry          = '0;
        issue_entry.valid    = 1'b1;
        issue_entry.rd       = rd_x;
        issue_entry.regwrite = hz.id_regwrite;
        issue_entry.memread  = hz.id_memread;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb[DEPTH:2] <= sb[DEPTH-1:1];
            sb[1]       <= hz.issue ? issue_entry : '0;
        end
    end

    pipe_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .sb       (sb),
        .src      (rs_x),
        .src_used (hz.id_uses_rs),
        .sel      (hz.fwd_a)
    );

    pipe_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .sb       (sb),
        .src      (rt_x),
        .src_used (hz.id_uses_rt),
        .sel      (hz.fwd_b)
    );

`ifdef PIPE_HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (hz.flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(5)) hif ();

`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl #(.DEPTH(3), .RA_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_HAZARD_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .hz        (hif)
    );

    typedef struct {
        string      nm;
        logic       stall;
        logic       flush;
        logic       issue;
        logic [2:0] fa;
        logic [2:0] fb;
        bit         chk_cnt;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    bit   nxt_chk = 0;
    int   nxt_sc  = 0;
    int   nxt_fc  = 0;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        cmp(e.nm, "stall", int'(hif.stall), int'(e.stall));
        cmp(e.nm, "flush", int'(hif.flush), int'(e.flush));
        cmp(e.nm, "issue", int'(hif.issue), int'(e.issue));
        cmp(e.nm, "fwd_a", int'(hif.fwd_a), int'(e.fa));
        cmp(e.nm, "fwd_b", int'(hif.fwd_b), int'(e.fb));
`ifdef PIPE_HAZARD_STATS_EN
        if (e.chk_cnt) begin
            cmp(e.nm, "stall_cnt", int'(stall_cnt), e.sc);
            cmp(e.nm, "flush_cnt", int'(flush_cnt), e.fc);
        end
`endif
    endtask

    // Two sample points per cycle: negedge, and just before the next posedge
    initial begin
        forever begin
            @(negedge clk);
            check_one();
            #3;
            check_one();
        end
    end

    task automatic drive(input bit r, input bit v, input int rs, input int rt,
                         input bit urs, input bit urt, input int rd,
                         input bit rw, input bit mr, input bit br);
        rst                 = r;
        hif.id_valid        = v;
        hif.id_rs           = 5'(rs);
        hif.id_rt           = 5'(rt);
        hif.id_uses_rs      = urs;
        hif.id_uses_rt      = urt;
        hif.id_rd           = 5'(rd);
        hif.id_regwrite     = rw;
        hif.id_memread      = mr;
        hif.ex_branch_taken = br;
    endtask

    task automatic expect_out(input string nm, input bit es, input bit ef,
                              input bit ei, input int efa, input int efb);
        exp_t e;
        e.nm = nm; e.stall = es; e.flush = ef; e.issue = ei;
        e.fa = 3'(efa); e.fb = 3'(efb);
        e.chk_cnt = nxt_chk; e.sc = nxt_sc; e.fc = nxt_fc;
        nxt_chk = 0;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input bit r, input bit v, input int rs,
                        input int rt, input bit urs, input bit urt, input int rd,
                        input bit rw, input bit mr, input bit br,
                        input bit es, input bit ef, input bit ei,
                        input int efa, input int efb);
        @(posedge clk);
        #1;
        drive(r, v, rs, rt, urs, urt, rd, rw, mr, br);
        expect_out(nm, es, ef, ei, efa, efb);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //   name          r v rs rt ur ut rd rw mr br   st fl is fa fb
        step("rst_idle",   1,0, 0, 0, 0,0, 0, 0,0,0,    0, 0, 0, 0, 0);
        step("rst_branch", 1,1, 3, 0, 1,0, 0, 0,0,1,    0, 1, 0, 0, 0);
        step("empty_sb",   0,1, 3, 4, 1,1, 0, 0,0,0,    0, 0, 1, 0, 0);
        step("add_r5",     0,1, 1, 2, 1,1, 5, 1,0,0,    0, 0, 1, 0, 0);
        step("fwd_ex",     0,1, 5, 6, 1,1, 8, 1,0,0,    0, 0, 1, 1, 0);
        step("fwd_mem",    0,1, 5, 8, 1,1, 0, 0,0,0,    0, 0, 1, 2, 1);
        step("fwd_wb",     0,1, 5, 8, 1,1, 0, 0,0,0,    0, 0, 1, 3, 2);
        step("add_r12a",   0,1, 1, 2, 1,1,12, 1,0,0,    0, 0, 1, 0, 0);
        step("add_r12b",   0,1, 0, 0, 1,1,12, 1,0,0,    0, 0, 1, 0, 0);
        step("youngest",   0,1,12, 0, 1,0, 0, 0,0,0,    0, 0, 1, 1, 0);
        step("lw_r7",      0,1, 1, 2, 1,1, 7, 1,1,0,    0, 0, 1, 0, 0);
        step("lu_stall",   0,1, 3, 7, 1,1, 0, 0,0,0,    1, 0, 0, 0, 0);
        step("lu_release", 0,1, 3, 7, 1,1, 0, 0,0,0,    0, 0, 1, 0, 2);
        step("lw_r9",      0,1, 1, 2, 1,1, 9, 1,1,0,    0, 0, 1, 0, 0);
        step("lu_flush",   0,1, 9, 2, 1,1, 0, 0,0,1,    0, 1, 0, 0, 0);
        step("post_flush", 0,1, 9, 2, 1,1, 0, 0,0,0,    0, 0, 1, 2, 0);
        step("add_r0",     0,1, 1, 2, 1,1, 0, 1,0,0,    0, 0, 1, 0, 0);
        step("lw_r0",      0,1, 1, 2, 1,1, 0, 1,1,0,    0, 0, 1, 0, 0);
        step("use_r0",     0,1, 0, 0, 1,1, 0, 0,0,0,    0, 0, 1, 0, 0);
        step("lw_r13",     0,1, 1, 2, 1,1,13, 1,1,0,    0, 0, 1, 0, 0);
        step("id_invalid", 0,0,13, 0, 1,0, 0, 0,0,0,    0, 0, 0, 0, 0);
        step("rs_unused",  0,1,13, 2, 0,1, 0, 0,0,0,    0, 0, 1, 0, 0);
        step("lw_r14",     0,1, 1, 2, 1,1,14, 1,1,0,    0, 0, 1, 0, 0);
        nxt_chk = 1; nxt_sc = 1; nxt_fc = 1;
        step("pre_rst",    0,1,14, 2, 1,1, 0, 0,0,0,    1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        expect_out("mid_rst", 0, 0, 1, 0, 0);
        nxt_chk = 1; nxt_sc = 0; nxt_fc = 0;
        step("after_rst",  0,1,14, 2, 1,1, 0, 0,0,0,    0, 0, 1, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 3, giving the number of in-flight stages tracked after decode (EX=1 ... WB=DEPTH); legal range 2..4.
REQ-002 SHALL provide parameter RA_W, default 5, giving the register address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 id_valid  in  1  decode slot holds a real instruction.
REQ-006 id_rs, id_rt  in  RA_W each  source registers of the decode instruction.
REQ-007 id_uses_rs, id_uses_rt  in  1 each  source actually read.
REQ-008 id_rd  in  RA_W  destination register of the decode instruction.
REQ-009 id_regwrite, id_memread  in  1 each  decode instruction writes a register / is a load.
REQ-010 ex_branch_taken  in  1  branch resolved taken in EX this cycle.
REQ-011 stall  out  1  hold PC and IF/ID, bubble into EX.
REQ-012 flush  out  1  discard IF/ID contents.
REQ-013 issue  out  1  decode instruction enters EX at this edge.
REQ-014 fwd_a, fwd_b  out  3 each  operand source: 0 = register file, k = result of stage k.

Function
REQ-015 SHALL hold a scoreboard of DEPTH entries {valid, rd, regwrite, memread}; entry 1 = EX, entry DEPTH = WB.
REQ-016 Each edge: entry k moves to k+1, entry DEPTH is discarded, entry 1 loads the decode fields if issue=1, otherwise a bubble (valid=0).
REQ-017 issue SHALL equal id_valid && !stall && !flush, combinationally.
REQ-018 Load-use: stall=1 when entry 1 is valid && memread && regwrite && rd!=0 && rd matches a used source (id_uses_rs/rt) of a valid decode instruction; otherwise 0.
REQ-019 A load-use stall SHALL last exactly one cycle; the bubble then lets the load reach stage 2 and be forwarded from there.
REQ-020 flush SHALL equal ex_branch_taken; when flush=1 stall SHALL be 0 (flush wins) and a bubble enters EX.
REQ-021 fwd_a SHALL be the lowest k with entry k valid && regwrite && rd!=0 && rd==id_rs, excluding k=1 when entry 1 is memread; 0 if no match or id_uses_rs=0. fwd_b likewise for id_rt.
REQ-022 Register 0 SHALL never match, stall, or forward.
REQ-023 stall, flush, issue, fwd_a and fwd_b SHALL be combinational from the registered scoreboard and current inputs, with zero-cycle latency.

Reset
REQ-024 rst=1 SHALL clear all scoreboard entries to valid=0 immediately, regardless of clk.
REQ-025 While the scoreboard is clear, stall=0 and fwd_a=fwd_b=0; flush follows ex_branch_taken.
REQ-026 Reset asserted mid-stall SHALL cancel the stall in the same cycle.

Configuration
REQ-027 Macro PIPE_HAZARD_STATS_EN: when defined, SHALL add outputs stall_cnt and flush_cnt (32 bits each) that increment on each cycle with stall=1 or flush=1, saturate at all-ones, and clear on rst.
REQ-028 When PIPE_HAZARD_STATS_EN is undefined, these ports and counters SHALL NOT exist.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the scoreboard entry struct, the constants FWD_RF=0 and REG_ZERO=0, and the fwd select width (3).
REQ-030 A single sub-module pipe_fwd_match SHALL compute one operand's forward select from the scoreboard and a source address; it is instantiated twice.

Verification
REQ-031 Reset, then id_valid=1 with rs=3, rt=4 and an empty scoreboard -> fwd_a=fwd_b=0, stall=0, issue=1.
REQ-032 Issue add rd=5, then next cycle an instruction using rs=5 -> fwd_a=1; one cycle later (independent instruction in between) -> fwd_a=2.
REQ-033 Issue lw rd=7, then a consumer with rt=7 -> stall=1 for exactly one cycle, issue=0, then fwd_b=2, issue=1.
REQ-034 A load-use condition together with ex_branch_taken=1 -> flush=1, stall=0, bubble in entry 1 on the next cycle.
REQ-035 Writes to rd=0 followed by a consumer of rs=0 -> fwd_a=0, stall=0.
REQ-036 rst asserted between edges during a stall -> stall drops immediately; with PIPE_HAZARD_STATS_EN defined, stall_cnt=0 after reset.
